mmcm_phase_shift_ctrl: RTL and testbench



---
 rtl/mmcm_phase_shift_ctrl.sv | 138 +++++++++++++
 tb/tb_mmcm_phase_shift_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_phase_shift_ctrl.sv
// Converts ph_inc/ph_dec request pulses into MMCM dynamic phase-shift steps and tracks position.
// Optional position bound is enabled by defining PS_LIMIT_EN.
module mmcm_phase_shift_ctrl #(
    parameter int STEP_N     = 8,
    parameter int PEND_WIDTH = 4,
    parameter int POS_WIDTH  = 16,
    parameter int TIMEOUT    = 64,
    parameter int PS_LIMIT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ph_inc,
    input  logic                        ph_dec,
    output logic                        psen,
    output logic                        psincdec,
    input  logic                        psdone,
    input  logic                        clr_err,
    output logic                        busy,
    output logic signed [PEND_WIDTH:0]  pending,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        timeout_err,
    output logic                        limit_hit
);

`ifdef PS_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int SW = PEND_WIDTH + 3;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = POS_WIDTH + 16;

    localparam logic signed [SW-1:0]        SUM_HI   = SW'(2**PEND_WIDTH - 1);
    localparam logic signed [SW-1:0]        SUM_LO   = -SUM_HI;
    localparam logic signed [SW-1:0]        SUM_ONE  = SW'(1);
    localparam logic        [TW-1:0]        TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic signed [LW-1:0]        LIM      = LW'(PS_LIMIT);
    localparam logic signed [LW-1:0]        STEP_W   = LW'(STEP_N);
    localparam logic signed [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t                     state;
    logic                       dir;
    logic [7:0]                 step_cnt;
    logic [TW-1:0]              timer;

    logic                       deq;
    logic                       dir_nxt;
    logic                       over;
    logic                       to_idle;
    logic signed [SW-1:0]       pend_sum;
    logic signed [PEND_WIDTH:0] pending_nxt;
    logic signed [LW-1:0]       target;

    always_comb begin
        // NOTE: every variable gets an unconditional value first so no latch can be inferred.
        deq      = (state == IDLE) && (pending != '0);
        dir_nxt  = ~pending[PEND_WIDTH];
        pend_sum = SW'(pending);
        if (ph_inc) pend_sum = pend_sum + SUM_ONE;
        if (ph_dec) pend_sum = pend_sum - SUM_ONE;
        if (deq)    pend_sum = dir_nxt ? pend_sum - SUM_ONE : pend_sum + SUM_ONE;
        // Requests beyond the saturation point are dropped without notice.
        if (pend_sum > SUM_HI)      pend_sum = SUM_HI;
        else if (pend_sum < SUM_LO) pend_sum = SUM_LO;
        pending_nxt = pend_sum[PEND_WIDTH:0];

        target  = LW'(position) + (dir_nxt ? STEP_W : -STEP_W);
        over    = LIMIT_EN && ((target > LIM) || (target < -LIM));
        to_idle = (state == GAP) || ((state == IDLE) && (pending == '0));
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dir         <= 1'b0;
            step_cnt    <= '0;
            timer       <= '0;
            psen        <= 1'b0;
            psincdec    <= 1'b0;
            pending     <= '0;
            position    <= '0;
            timeout_err <= 1'b0;
            limit_hit   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pending   <= pending_nxt;
            busy      <= !to_idle || (pending_nxt != '0);
            psen      <= 1'b0;
            limit_hit <= 1'b0;
            // A timeout raised below in the same cycle overrides this clear.
            if (clr_err) timeout_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (deq) begin
                        dir      <= dir_nxt;
                        step_cnt <= 8'(STEP_N);
                        if (over) begin
                            limit_hit <= 1'b1;
                            state     <= GAP;
                        end else begin
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    psen     <= 1'b1;
                    psincdec <= dir;
                    timer    <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (psdone) begin
                        position <= position + (dir ? POS_ONE : -POS_ONE);
                        step_cnt <= step_cnt - 8'd1;
                        state    <= (step_cnt == 8'd1) ? GAP : ISSUE;
                    end else if (timer == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_phase_shift_ctrl.sv
// Directed bench for mmcm_phase_shift_ctrl with an MMCM psdone model and a psincdec scoreboard.
module tb_mmcm_phase_shift_ctrl;

    localparam int STEP_N     = 8;
    localparam int PEND_WIDTH = 4;
    localparam int POS_WIDTH  = 16;
    localparam int TIMEOUT    = 64;
`ifdef PS_LIMIT_EN
    localparam int PS_LIMIT   = 16;
`else
    localparam int PS_LIMIT   = 1024;
`endif
    localparam int DONE_DELAY = 12;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        ph_inc = 1'b0;
    logic                        ph_dec = 1'b0;
    logic                        psdone = 1'b0;
    logic                        clr_err = 1'b0;
    logic                        psen;
    logic                        psincdec;
    logic                        busy;
    logic signed [PEND_WIDTH:0]  pending;
    logic signed [POS_WIDTH-1:0] position;
    logic                        timeout_err;
    logic                        limit_hit;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_due = -1;
    int last_psen_cyc = -1;
    int last_done_cyc = -1;
    bit mmcm_silent = 1'b0;
    logic prev_psen = 1'b0;
    bit exp_q[$];

    mmcm_phase_shift_ctrl #(
        .STEP_N(STEP_N), .PEND_WIDTH(PEND_WIDTH), .POS_WIDTH(POS_WIDTH),
        .TIMEOUT(TIMEOUT), .PS_LIMIT(PS_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .ph_inc(ph_inc), .ph_dec(ph_dec),
        .psen(psen), .psincdec(psincdec), .psdone(psdone), .clr_err(clr_err),
        .busy(busy), .pending(pending), .position(position),
        .timeout_err(timeout_err), .limit_hit(limit_hit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // MMCM model and psen monitor: each psen pops one expected direction.
    always @(negedge clk) begin
        psdone = 1'b0;
        if (rst) done_due = -1;
        if (psen === 1'b1) begin
            check("psen_width", prev_psen, 0);
            check("psen_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("psincdec", psincdec, exp_q.pop_front());
            last_psen_cyc = cyc;
            if (!mmcm_silent) done_due = cyc + DONE_DELAY;
        end
        if (cyc == done_due) begin
            psdone        = 1'b1;
            last_done_cyc = cyc;
            done_due      = -1;
        end
        prev_psen = psen;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_steps(input bit dir, input int groups);
        for (int i = 0; i < groups * STEP_N; i++) exp_q.push_back(dir);
    endtask

    task automatic pulse_inc();
        @(negedge clk) ph_inc = 1'b1;
        @(negedge clk) ph_inc = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_psen", psen, 0);
        check("rst_psincdec", psincdec, 0);
        check("rst_pending", pending, 0);
        check("rst_position", position, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_limit_hit", limit_hit, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: latency, eight increments, busy drops after GAP.
        push_steps(1'b1, 1);
        pulse_inc();
        check("lat_pending_c1", pending, 1);
        check("lat_busy_c1", busy, 1);
        @(negedge clk);
        check("lat_psen_c2", psen, 0);
        check("lat_dequeued_c2", pending, 0);
        @(negedge clk);
        check("lat_psen_c3", psen, 1);
        wait_idle("inc_idle", 400);
        check("inc_busy_after_gap", cyc - last_done_cyc, 2);
        check("inc_position", position, 8);
        check("inc_pending", pending, 0);
        check("inc_sb_empty", exp_q.size(), 0);

        // Simultaneous inc and dec cancel.
        @(negedge clk) begin ph_inc = 1'b1; ph_dec = 1'b1; end
        @(negedge clk) begin ph_inc = 1'b0; ph_dec = 1'b0; end
        check("cancel_pending", pending, 0);
        check("cancel_busy", busy, 0);
        repeat (20) @(negedge clk);
        check("cancel_position", position, 8);

`ifndef PS_LIMIT_EN
        // Three back-to-back decrements.
        do_reset();
        push_steps(1'b0, 3);
        @(negedge clk) ph_dec = 1'b1;
        @(negedge clk) check("dec_pending_c1", pending, -1);
        @(negedge clk) check("dec_pending_c2", pending, -1);
        @(negedge clk) ph_dec = 1'b0;
        check("dec_pending_c3", pending, -2);
        wait_idle("dec_idle", 1200);
        check("dec_position", position, -24);

        // Opposite requests during a group only queue; the group completes first.
        push_steps(1'b1, 1);
        push_steps(1'b0, 2);
        pulse_inc();
        repeat (5) @(negedge clk);
        ph_dec = 1'b1;
        @(negedge clk);
        @(negedge clk) ph_dec = 1'b0;
        check("rev_pending", pending, -2);
        wait_idle("rev_idle", 1200);
        check("rev_position", position, -32);

        // Twenty requests saturate the pending counter at +15.
        do_reset();
        push_steps(1'b1, 16);
        for (int i = 0; i < 20; i++) @(negedge clk) ph_inc = 1'b1;
        @(negedge clk) ph_inc = 1'b0;
        check("sat_pending", pending, 15);
        wait_idle("sat_idle", 4000);
        check("sat_position", position, 128);
        check("sat_sb_empty", exp_q.size(), 0);
`endif

        // MMCM never answers: timeout after 64 cycles, request abandoned.
        do_reset();
        mmcm_silent = 1'b1;
        push_steps(1'b1, 0);
        exp_q.push_back(1'b1);
        pulse_inc();
        n = 0;
        while (timeout_err !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_set", timeout_err, 1);
        check("tmo_delay", cyc - last_psen_cyc, TIMEOUT);
        check("tmo_position", position, 0);
        @(negedge clk);
        check("tmo_back_idle", busy, 0);
        repeat (5) @(negedge clk);
        check("tmo_sticky", timeout_err, 1);
        clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        check("tmo_cleared", timeout_err, 0);
        mmcm_silent = 1'b0;

`ifdef PS_LIMIT_EN
        // Position bound: third request would exceed +16 and is dropped.
        do_reset();
        for (int g = 0; g < 2; g++) begin
            push_steps(1'b1, 1);
            pulse_inc();
            wait_idle("lim_idle", 400);
        end
        check("lim_position_16", position, 16);
        pulse_inc();
        @(negedge clk);
        check("lim_hit_pulse", limit_hit, 1);
        @(negedge clk);
        check("lim_hit_one_cycle", limit_hit, 0);
        wait_idle("lim_final_idle", 50);
        check("lim_position_held", position, 16);
`else
        check("nolim_limit_hit", limit_hit, 0);
`endif

        check("final_sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1);
    end

endmodule
